mem_arbiter_rr: RTL and testbench

//  N-master memory arbiter between CPU-side requesters (fetch, data, later DMA/debug) and one

---
 rtl/mem_arbiter_rr_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_pick.sv | 31 +++
 rtl/mem_arbiter_rr.sv | 126 ++++++++++++
 tb/tb_mem_arbiter_rr.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and defaults for the N-master RAM arbiter.
package mem_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DONE
  } arb_state_t;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  // (base + off) mod n for base, off < n; avoids a divider for non-power-of-two n.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational masked-priority pick: first requester at or after ptr (round-robin)
// or lowest set index (fixed priority).
module rr_pick
  import mem_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_M = 2,
  localparam int unsigned IDX_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_en,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             valid_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_idx_c = '0;
    valid_c     = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      cand = rr_en ? IDX_W'(wrap_idx(32'(ptr), i, NUM_M)) : IDX_W'(i);
      if (!valid_c && req[cand]) begin
        grant_idx_c = cand;
        valid_c     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-master arbiter onto one variable-latency RAM port: one access in flight,
// round-robin or fixed-priority grant, optional per-access timeout.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_M   = 2,
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter int unsigned RR_EN   = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_req,
  input  logic [NUM_M-1:0]          m_wen,
  input  logic [NUM_M*ADDR_W-1:0]   m_addr,
  input  logic [NUM_M*DATA_W-1:0]   m_wdata,
  input  logic [NUM_M*DATA_W/8-1:0] m_strb,
  output logic [NUM_M-1:0]          m_done,
  output logic                      m_err,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      ram_ren,
  output logic                      ram_wen,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_store,
  output logic [DATA_W/8-1:0]       ram_strb,
  input  logic [DATA_W-1:0]         ram_load,
  input  logic                      ram_ready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_M);
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic             wr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] pick_idx_c;
  logic             pick_vld_c;
  logic             timeout_hit_c;

  rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req         (m_req),
    .ptr         (ptr_q),
    .rr_en       (RR_EN != 0),
    .grant_idx_c (pick_idx_c),
    .valid_c     (pick_vld_c)
  );

  // cnt_q holds the number of BUSY cycles already elapsed, so this flags the TIMEOUT-th one.
  assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      m_done    <= '0;
      m_err     <= 1'b0;
      m_rdata   <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
      ram_strb  <= '0;
    end else begin
      m_done <= '0;
      m_err  <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_vld_c) begin
            grant_q  <= pick_idx_c;
            wr_q     <= m_wen[pick_idx_c];
            ram_addr <= m_addr[32'(pick_idx_c) * ADDR_W +: ADDR_W];
            if (m_wen[pick_idx_c]) begin
              ram_store <= m_wdata[32'(pick_idx_c) * DATA_W +: DATA_W];
              ram_strb  <= m_strb[32'(pick_idx_c) * STRB_W +: STRB_W];
            end else begin
              ram_store <= '0;
              ram_strb  <= '1;
            end
            ram_ren <= ~m_wen[pick_idx_c];
            ram_wen <= m_wen[pick_idx_c];
            cnt_q   <= '0;
            if (RR_EN != 0) begin
              ptr_q <= IDX_W'(wrap_idx(32'(pick_idx_c), 1, NUM_M));
            end
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // A ready arriving on the timeout cycle still counts as success.
          if (ram_ready) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            m_done  <= NUM_M'(1) << grant_q;
            m_rdata <= wr_q ? '0 : ram_load;
            state_q <= ARB_DONE;
          end else if (timeout_hit_c) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            m_done  <= NUM_M'(1) << grant_q;
            m_err   <= 1'b1;
            m_rdata <= '0;
            state_q <= ARB_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ARB_DONE: begin
          m_rdata <= '0;
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share stimulus and a RAM model.
module tb_mem_arbiter_rr;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req;
  logic [NM-1:0]     m_wen;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM*DW/8-1:0] m_strb;
  logic [DW-1:0]     ram_load;
  logic              ram_ready;

  logic [NM-1:0]     m_done, m_done_f;
  logic              m_err, m_err_f;
  logic [DW-1:0]     m_rdata, m_rdata_f;
  logic              ram_ren, ram_ren_f, ram_wen, ram_wen_f;
  logic [AW-1:0]     ram_addr, ram_addr_f;
  logic [DW-1:0]     ram_store, ram_store_f;
  logic [DW/8-1:0]   ram_strb, ram_strb_f;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .RR_EN(1), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_strb(m_strb), .m_done(m_done), .m_err(m_err),
    .m_rdata(m_rdata), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_strb(ram_strb), .ram_load(ram_load), .ram_ready(ram_ready)
  );

  mem_arbiter_rr #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .RR_EN(0), .TIMEOUT(4)) dut_fp (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_strb(m_strb), .m_done(m_done_f), .m_err(m_err_f),
    .m_rdata(m_rdata_f), .ram_ren(ram_ren_f), .ram_wen(ram_wen_f), .ram_addr(ram_addr_f),
    .ram_store(ram_store_f), .ram_strb(ram_strb_f), .ram_load(ram_load), .ram_ready(ram_ready)
  );

  typedef struct {
    int          g;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  exp_t        qf[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          model_ptr = 0;
  bit          mon_en = 1'b0;
  int          ram_lat = 1;
  logic [31:0] ram_data = '0;
  int          busy_cyc = 0;

  function automatic int pick_rr(input logic [1:0] req, input int p);
    for (int i = 0; i < 2; i++) begin
      int c;
      c = (p + i) % 2;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  function automatic int pick_fixed(input logic [1:0] req);
    return req[0] ? 0 : 1;
  endfunction

  task automatic push_exp(input logic [1:0] req, input bit err, input logic [31:0] rd);
    exp_t e;
    e.g = pick_rr(req, model_ptr);
    e.err = err;
    e.rdata = rd;
    q.push_back(e);
    model_ptr = (e.g + 1) % 2;
    e.g = pick_fixed(req);
    qf.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (m_done == '0 && cyc < max_cyc);
  endtask

  // RAM model: ready after ram_lat strobe cycles (never when ram_lat <= 0).
  always @(negedge clk) begin
    if (ram_ren || ram_wen) begin
      busy_cyc = busy_cyc + 1;
      if (ram_lat > 0 && busy_cyc == ram_lat) begin
        ram_ready = 1'b1;
        ram_load  = ram_data;
      end else begin
        ram_ready = 1'b0;
        ram_load  = $urandom;
      end
    end else begin
      busy_cyc  = 0;
      ram_ready = 1'b0;
    end
  end

  // Scoreboard: every completion pulse pops and checks one expected access per arbiter.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [1:0]  oh;
    if (mon_en && m_done !== 2'b00) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL rr_done_unexpected: m_done=%b with nothing outstanding", m_done);
      end else begin
        e  = q.pop_front();
        oh = 2'(1) << e.g;
        if ({m_done, m_err, m_rdata} !== {oh, e.err, e.rdata}) begin
          n_bad++;
          $display("FAIL rr_done: got done=%b err=%b rdata=%h, want done=%b err=%b rdata=%h",
                   m_done, m_err, m_rdata, oh, e.err, e.rdata);
        end
      end
    end
    if (mon_en && m_done_f !== 2'b00) begin
      n_cmp++;
      if (qf.size() == 0) begin
        n_bad++;
        $display("FAIL fp_done_unexpected: m_done=%b with nothing outstanding", m_done_f);
      end else begin
        e  = qf.pop_front();
        oh = 2'(1) << e.g;
        if ({m_done_f, m_err_f, m_rdata_f} !== {oh, e.err, e.rdata}) begin
          n_bad++;
          $display("FAIL fp_done: got done=%b err=%b rdata=%h, want done=%b err=%b rdata=%h",
                   m_done_f, m_err_f, m_rdata_f, oh, e.err, e.rdata);
        end
      end
    end
  end

  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    m_req = 2'($urandom);
    m_wen = '0; m_addr = '0; m_wdata = '0; m_strb = '0;
    tick();
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({m_done, m_err, m_rdata, ram_ren, ram_wen, ram_addr, ram_store, ram_strb} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: done=%b err=%b ren=%b wen=%b addr=%h strb=%b, want all 0",
                 m_done, m_err, ram_ren, ram_wen, ram_addr, ram_strb);
      end
      m_req = 2'($urandom);
      if (i == 0) tick();
    end
    model_ptr = 0;
    ram_lat = 1;
    ram_data = 32'hA5A5_0001;
    push_exp(2'b11, 1'b0, 32'hA5A5_0001);
    rst = 1'b0;
    m_req = 2'b11;
    wait_done(10, cyc);
    n_cmp++;
    if (m_done == '0 || cyc != 2) begin
      n_bad++;
      $display("FAIL first_grant_latency: cycles=%0d done=%b, want 2 cycles", cyc, m_done);
    end
    m_req = '0;
    tick();
  endtask

  task automatic test_single_read();
    int cyc;
    m_wen = '0;
    m_addr[31:0] = 32'h100;
    ram_lat = 3;
    ram_data = 32'hDEAD_BEEF;
    push_exp(2'b01, 1'b0, 32'hDEAD_BEEF);
    m_req = 2'b01;
    tick();
    n_cmp++;
    if ({ram_ren, ram_wen, ram_addr, ram_strb} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      n_bad++;
      $display("FAIL read_issue: ren=%b wen=%b addr=%h strb=%b, want 1 0 00000100 1111",
               ram_ren, ram_wen, ram_addr, ram_strb);
    end
    wait_done(10, cyc);
    n_cmp++;
    if (m_done == '0 || cyc != 3) begin
      n_bad++;
      $display("FAIL read_latency: cycles after issue=%0d done=%b, want 3", cyc, m_done);
    end
    m_req = '0;
    tick();
    n_cmp++;
    if (m_done !== '0) begin
      n_bad++;
      $display("FAIL read_done_width: m_done=%b on second cycle, want 00", m_done);
    end
  endtask

  task automatic test_write_strb();
    int cyc;
    m_wen = 2'b10;
    m_addr[63:32] = 32'h40;
    m_wdata[63:32] = 32'h1122_3344;
    m_wdata[31:0] = 32'hFFFF_FFFF;
    m_strb = 8'b0011_1111;
    ram_lat = 3;
    ram_data = 32'hCAFE_F00D;
    push_exp(2'b10, 1'b0, 32'h0);
    m_req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({ram_ren, ram_wen, ram_addr, ram_store, ram_strb} !==
          {1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'b0011}) begin
        n_bad++;
        $display("FAIL write_hold[%0d]: ren=%b wen=%b addr=%h store=%h strb=%b, want 0 1 00000040 11223344 0011",
                 i, ram_ren, ram_wen, ram_addr, ram_store, ram_strb);
      end
    end
    wait_done(5, cyc);
    n_cmp++;
    if (m_done == '0 || cyc != 1) begin
      n_bad++;
      $display("FAIL write_latency: cycles=%0d done=%b, want 1", cyc, m_done);
    end
    m_req = '0;
    m_wen = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int cyc;
    ram_lat = 1;
    ram_data = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) push_exp(2'b11, 1'b0, 32'h0BAD_F00D);
    m_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(8, cyc);
      n_cmp++;
      if (m_done == '0 || cyc != ((k == 0) ? 2 : 3)) begin
        n_bad++;
        $display("FAIL rr_spacing[%0d]: cycles=%0d done=%b, want %0d", k, cyc, m_done,
                 (k == 0) ? 2 : 3);
      end
    end
    m_req = '0;
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    int cyc;
    for (int r = 0; r < 2; r++) begin
      ram_lat = (r == 0) ? -1 : 4;
      ram_data = 32'h1234_5678;
      push_exp(2'b01, (r == 0), (r == 0) ? 32'h0 : 32'h1234_5678);
      m_req = 2'b01;
      cnt = 0;
      cyc = 0;
      do begin
        tick();
        cyc++;
        if (ram_ren) cnt++;
      end while (m_done == '0 && cyc < 12);
      n_cmp++;
      if (m_done == '0 || cnt != 4 || ram_ren !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_strobe[%0d]: strobe cycles=%0d done=%b ren=%b, want 4 cycles then done",
                 r, cnt, m_done, ram_ren);
      end
      m_req = '0;
      tick();
    end
  endtask

  task automatic test_mid_op_reset();
    int cyc;
    ram_lat = -1;
    m_req = 2'b01;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({ram_ren, ram_wen, m_done, ram_ren_f, m_done_f} !== '0) begin
      n_bad++;
      $display("FAIL midop_reset: ren=%b wen=%b done=%b, want 0 0 00", ram_ren, ram_wen, m_done);
    end
    rst = 1'b0;
    m_req = '0;
    model_ptr = 0;
    tick();
    tick();
    n_cmp++;
    if ({ram_ren, m_done} !== '0) begin
      n_bad++;
      $display("FAIL midop_idle: ren=%b done=%b after reset, want 0 00", ram_ren, m_done);
    end
    ram_lat = 2;
    ram_data = 32'h5555_AAAA;
    push_exp(2'b11, 1'b0, 32'h5555_AAAA);
    m_req = 2'b11;
    wait_done(10, cyc);
    n_cmp++;
    if (m_done == '0 || cyc != 3) begin
      n_bad++;
      $display("FAIL midop_recover: cycles=%0d done=%b, want 3", cyc, m_done);
    end
    m_req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_strb();
    test_round_robin();
    test_timeout();
    test_mid_op_reset();
    repeat (3) tick();
    n_cmp++;
    if (q.size() != 0 || qf.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: rr left=%0d fp left=%0d, want 0 0", q.size(), qf.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
